// File: rtl/ucie_ctl_phy_sb_tx_arb.sv
// UCIe sideband TX arbiter: merges adapter and PHY (LTSM) requester flit
// streams onto one sideband TX path, message-atomic, credit-gated.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_adp_vld/last/data, o_adp_rdy adapter requester flit handshake
//   i_phy_vld/last/data, o_phy_rdy PHY-internal requester flit handshake
//   o_sb_data_valid, o_data_sent_sb, o_sb_last  registered TX flit
//   i_sb_crd_rtn                   one-cycle remote credit return pulse
//   o_crd_cnt, o_crd_ovf           credit count, sticky overflow flag
//
// Config macro: UCIE_CTL_SB_ARB_PHY_PRIO_EN -- when defined the PHY
// requester wins every simultaneous request (fixed priority); otherwise
// simultaneous requests are resolved round-robin per message.
module ucie_ctl_phy_sb_tx_arb #(
    parameter int NC      = 32,
    parameter int CRD_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_adp_vld,
    input  logic          i_adp_last,
    input  logic [NC-1:0] i_adp_data,
    output logic          o_adp_rdy,
    input  logic          i_phy_vld,
    input  logic          i_phy_last,
    input  logic [NC-1:0] i_phy_data,
    output logic          o_phy_rdy,
    output logic          o_sb_data_valid,
    output logic [NC-1:0] o_data_sent_sb,
    output logic          o_sb_last,
    input  logic          i_sb_crd_rtn,
    output logic [3:0]    o_crd_cnt,
    output logic          o_crd_ovf
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_XFER_ADP = 2'd1,
        S_XFER_PHY = 2'd2
    } state_t;

    localparam logic [3:0] LP_CRD_MAX = 4'(CRD_MAX);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr_adp;     // 1: adapter owned the most recent grant
    logic [3:0]    r_crd;
    logic          r_ovf;
    logic          r_sb_vld;
    logic          r_sb_last;
    logic [NC-1:0] r_sb_data;

    logic          w_pick_adp;
    logic          w_grant;
    logic          w_consume;
    logic          w_acc;
    logic          w_acc_last;
    logic [NC-1:0] w_acc_data;
    logic [3:0]    w_crd_after;

    // Winner among simultaneous requests in IDLE.
`ifdef UCIE_CTL_SB_ARB_PHY_PRIO_EN
    assign w_pick_adp = i_adp_vld & ~i_phy_vld;
`else
    assign w_pick_adp = i_adp_vld & (~i_phy_vld | ~r_ptr_adp);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_consume   = 1'b0;
        w_acc       = 1'b0;
        w_acc_last  = 1'b0;
        w_acc_data  = '0;
        unique case (r_state)
            S_IDLE: begin
                if ((r_crd != 4'd0) && (i_adp_vld || i_phy_vld)) begin
                    w_grant     = 1'b1;
                    w_consume   = 1'b1;
                    w_state_nxt = w_pick_adp ? S_XFER_ADP : S_XFER_PHY;
                end
            end
            S_XFER_ADP: begin
                if (i_adp_vld) begin
                    w_acc      = 1'b1;
                    w_acc_last = i_adp_last;
                    w_acc_data = i_adp_data;
                    if (i_adp_last) w_state_nxt = S_IDLE;
                end
            end
            S_XFER_PHY: begin
                if (i_phy_vld) begin
                    w_acc      = 1'b1;
                    w_acc_last = i_phy_last;
                    w_acc_data = i_phy_data;
                    if (i_phy_last) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A return that would push past CRD_MAX (after this cycle's consume)
    // saturates and flags overflow.
    assign w_crd_after = r_crd - {3'b000, w_consume};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr_adp <= 1'b0;
            r_crd     <= LP_CRD_MAX;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_ptr_adp <= w_pick_adp;
            if (i_sb_crd_rtn) begin
                if (w_crd_after == LP_CRD_MAX) begin
                    r_crd <= w_crd_after;
                    r_ovf <= 1'b1;
                end else begin
                    r_crd <= w_crd_after + 4'd1;
                end
            end else begin
                r_crd <= w_crd_after;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sb_vld  <= 1'b0;
            r_sb_last <= 1'b0;
            r_sb_data <= '0;
        end else begin
            r_sb_vld  <= w_acc;
            r_sb_last <= w_acc & w_acc_last;
            if (w_acc) r_sb_data <= w_acc_data;
        end
    end

    assign o_adp_rdy       = (r_state == S_XFER_ADP);
    assign o_phy_rdy       = (r_state == S_XFER_PHY);
    assign o_sb_data_valid = r_sb_vld;
    assign o_sb_last       = r_sb_last;
    assign o_data_sent_sb  = r_sb_data;
    assign o_crd_cnt       = r_crd;
    assign o_crd_ovf       = r_ovf;

endmodule

// File: tb/tb_ucie_ctl_phy_sb_tx_arb.sv
// Testbench for ucie_ctl_phy_sb_tx_arb: directed scenarios then random
// traffic, checked cycle by cycle against a behavioural message model.
module tb_ucie_ctl_phy_sb_tx_arb;

    localparam int NC      = 32;
    localparam int CRD_MAX = 4;

    typedef struct packed {
        logic          l;
        logic [NC-1:0] d;
    } flit_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_adp_vld, i_adp_last, o_adp_rdy;
    logic [NC-1:0] i_adp_data;
    logic          i_phy_vld, i_phy_last, o_phy_rdy;
    logic [NC-1:0] i_phy_data;
    logic          o_sb_data_valid, o_sb_last, i_sb_crd_rtn, o_crd_ovf;
    logic [NC-1:0] o_data_sent_sb;
    logic [3:0]    o_crd_cnt;

    always #5 clk = ~clk;

    ucie_ctl_phy_sb_tx_arb #(.NC(NC), .CRD_MAX(CRD_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_adp_vld(i_adp_vld), .i_adp_last(i_adp_last),
        .i_adp_data(i_adp_data), .o_adp_rdy(o_adp_rdy),
        .i_phy_vld(i_phy_vld), .i_phy_last(i_phy_last),
        .i_phy_data(i_phy_data), .o_phy_rdy(o_phy_rdy),
        .o_sb_data_valid(o_sb_data_valid), .o_data_sent_sb(o_data_sent_sb),
        .o_sb_last(o_sb_last), .i_sb_crd_rtn(i_sb_crd_rtn),
        .o_crd_cnt(o_crd_cnt), .o_crd_ovf(o_crd_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Pending flits of each requester; front is the flit on offer.
    flit_t         q_adp[$];
    flit_t         q_phy[$];
    logic [NC-1:0] obs_q[$];
    bit            hold_adp = 0, hold_phy = 0, rtn_req = 0;

    // Reference model: who owns the link (0 none, 1 adp, 2 phy), credits,
    // overflow, who won last, and the flit expected on the output.
    int            m_owner;
    int            m_crd;
    bit            m_ovf;
    bit            m_adp_last;
    bit            m_vld;
    bit            m_last;
    logic [NC-1:0] m_data;

    task automatic chk(string tag, logic [NC-1:0] got, logic [NC-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_crd = CRD_MAX; m_ovf = 0; m_adp_last = 0;
        m_vld = 0; m_last = 0; m_data = '0;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".adp_rdy"}, NC'(o_adp_rdy), NC'(m_owner == 1));
        chk({tag, ".phy_rdy"}, NC'(o_phy_rdy), NC'(m_owner == 2));
        chk({tag, ".vld"}, NC'(o_sb_data_valid), NC'(m_vld));
        chk({tag, ".last"}, NC'(o_sb_data_valid & o_sb_last),
            NC'(m_vld & m_last));
        chk({tag, ".data"}, o_data_sent_sb, m_data);
        chk({tag, ".crd"}, NC'(o_crd_cnt), NC'(m_crd));
        chk({tag, ".ovf"}, NC'(o_crd_ovf), NC'(m_ovf));
    endtask

    // One clock: offer flits, advance the model, check at the negedge.
    task automatic step(string tag);
        bit    av, pv, acc_a, acc_p, win_adp;
        flit_t fa, fp;
        av = (q_adp.size() > 0) && !hold_adp;
        pv = (q_phy.size() > 0) && !hold_phy;
        fa = av ? q_adp[0] : '0;
        fp = pv ? q_phy[0] : '0;
        i_adp_vld = av; i_adp_last = fa.l; i_adp_data = fa.d;
        i_phy_vld = pv; i_phy_last = fp.l; i_phy_data = fp.d;
        i_sb_crd_rtn = rtn_req;

        acc_a = (m_owner == 1) && av;
        acc_p = (m_owner == 2) && pv;
        m_vld = acc_a || acc_p;
        if (acc_a) begin m_data = fa.d; m_last = fa.l; end
        if (acc_p) begin m_data = fp.d; m_last = fp.l; end
        if (m_owner == 0) begin
            if (m_crd > 0 && (av || pv)) begin
`ifdef UCIE_CTL_SB_ARB_PHY_PRIO_EN
                win_adp = av && !pv;
`else
                win_adp = av && (!pv || !m_adp_last);
`endif
                m_owner    = win_adp ? 1 : 2;
                m_adp_last = win_adp;
                m_crd--;
            end
        end else if ((acc_a && fa.l) || (acc_p && fp.l)) begin
            m_owner = 0;
        end
        if (rtn_req) begin
            if (m_crd == CRD_MAX) m_ovf = 1;
            else m_crd++;
        end

        @(posedge clk);
        if (acc_a) void'(q_adp.pop_front());
        if (acc_p) void'(q_phy.pop_front());
        rtn_req = 0;
        @(negedge clk);
        if (o_sb_data_valid) obs_q.push_back(o_data_sent_sb);
        check_model(tag);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic do_reset(string tag);
        rst_n = 1'b0;
        i_adp_vld = 0; i_phy_vld = 0; i_sb_crd_rtn = 0;
        q_adp.delete(); q_phy.delete(); obs_q.delete();
        hold_adp = 0; hold_phy = 0; rtn_req = 0;
        #1;
        model_reset();
        check_model({tag, ".rst"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_msg(bit adp, int len, logic [NC-1:0] base);
        for (int i = 0; i < len; i++) begin
            if (adp) q_adp.push_back({(i == len - 1), base + NC'(i)});
            else     q_phy.push_back({(i == len - 1), base + NC'(i)});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_adp_vld = 0; i_adp_last = 0; i_adp_data = '0;
        i_phy_vld = 0; i_phy_last = 0; i_phy_data = '0;
        i_sb_crd_rtn = 0;
        @(negedge clk);

        // Single 3-flit adapter message.
        do_reset("t1");
        push_msg(1, 3, 32'hA0);
        step("t1");
        chk("t1.rdy_after_vld", NC'(o_adp_rdy), NC'(1));
        chk("t1.crd_4to3", NC'(o_crd_cnt), NC'(3));
        repeat (3) step("t1");
        chk("t1.last_flag", NC'(o_sb_last), NC'(1));
        chk("t1.last_data", o_data_sent_sb, 32'hA2);
        repeat (2) step("t1");

        // Continuous 1-flit requests from both sides.
        do_reset("t2");
        for (int i = 0; i < 3; i++) begin
            push_msg(1, 1, 32'hA000_0000 + NC'(i));
            push_msg(0, 1, 32'hB000_0000 + NC'(i));
        end
        repeat (20) step("t2");
        chk("t2.count", NC'(obs_q.size()), NC'(4));
`ifdef UCIE_CTL_SB_ARB_PHY_PRIO_EN
        for (int i = 0; i < 3; i++)
            chk("t2.order", obs_q[i] >> 28, 32'hB);
`else
        for (int i = 0; i < 4; i++)
            chk("t2.order", obs_q[i] >> 28, (i % 2 == 0) ? 32'hA : 32'hB);
`endif

        // Credit exhaustion and return.
        do_reset("t3");
        for (int i = 0; i < 5; i++) push_msg(1, 1, 32'hC0 + NC'(i));
        repeat (16) step("t3");
        chk("t3.crd_zero", NC'(o_crd_cnt), NC'(0));
        chk("t3.waiting", NC'(o_adp_rdy), NC'(0));
        chk("t3.issued", NC'(obs_q.size()), NC'(4));
        rtn_req = 1;
        step("t3");
        chk("t3.rtn_no_gnt", NC'(o_adp_rdy), NC'(0));
        step("t3");
        chk("t3.gnt_after_rtn", NC'(o_adp_rdy), NC'(1));
        repeat (3) step("t3");

        // Return coincident with consume, then overflow.
        do_reset("t4");
        push_msg(1, 1, 32'hD0);
        push_msg(1, 1, 32'hD1);
        repeat (8) step("t4");
        chk("t4.crd2", NC'(o_crd_cnt), NC'(2));
        push_msg(1, 1, 32'hD2);
        rtn_req = 1;
        step("t4");
        chk("t4.rtn_and_use", NC'(o_crd_cnt), NC'(2));
        repeat (3) step("t4");
        rtn_req = 1; step("t4");
        rtn_req = 1; step("t4");
        chk("t4.crd_full", NC'(o_crd_cnt), NC'(4));
        chk("t4.no_ovf", NC'(o_crd_ovf), NC'(0));
        rtn_req = 1; step("t4");
        chk("t4.crd_sat", NC'(o_crd_cnt), NC'(4));
        chk("t4.ovf_set", NC'(o_crd_ovf), NC'(1));
        repeat (2) step("t4");
        chk("t4.ovf_sticky", NC'(o_crd_ovf), NC'(1));

        // Adapter bubbles mid-message while PHY waits.
        do_reset("t5");
        push_msg(1, 3, 32'hE0);
        step("t5");
        step("t5");
        hold_adp = 1;
        push_msg(0, 1, 32'hF0);
        step("t5");
        chk("t5.bubble1", NC'(o_sb_data_valid), NC'(0));
        step("t5");
        chk("t5.bubble2", NC'(o_sb_data_valid), NC'(0));
        chk("t5.phy_blocked", NC'(o_phy_rdy), NC'(0));
        chk("t5.hold_data", o_data_sent_sb, 32'hE0);
        hold_adp = 0;
        step("t5");
        chk("t5.resume", o_data_sent_sb, 32'hE1);
        repeat (6) step("t5");
        chk("t5.phy_done", NC'(q_phy.size()), NC'(0));

        // Reset in the middle of a 4-flit message.
        do_reset("t6");
        push_msg(1, 4, 32'h60);
        repeat (3) step("t6");
        do_reset("t6mid");
        push_msg(0, 2, 32'h70);
        step("t6post");
        chk("t6.no_flit", NC'(o_sb_data_valid), NC'(0));
        repeat (4) step("t6post");
        chk("t6.clean_msg", obs_q[0], 32'h70);

        // Random traffic.
        do_reset("rnd");
        for (int n = 0; n < 3000; n++) begin
            if (q_adp.size() == 0 && $urandom_range(3) == 0)
                push_msg(1, $urandom_range(4, 1), $urandom);
            if (q_phy.size() == 0 && $urandom_range(3) == 0)
                push_msg(0, $urandom_range(4, 1), $urandom);
            hold_adp = ($urandom_range(4) == 0);
            hold_phy = ($urandom_range(4) == 0);
            rtn_req  = ($urandom_range(5) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
